// File: rtl/apb4_rng_fetch_pkg.sv
// Register map, control value and FSM encodings shared by the apb4_rng_fetch master.
package apb4_rng_fetch_pkg;

    localparam logic [31:0] RNG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] RNG_SEED    = 32'h0000_0004;
    localparam logic [31:0] RNG_VAL     = 32'h0000_0008;
    localparam logic [31:0] RNG_CTRL_EN = 32'h0000_0001;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } fsm_state_e;

    typedef enum logic [1:0] {
        PhSeed,
        PhCtrl,
        PhFetch
    } phase_e;

    function automatic logic [31:0] phase_offset(phase_e ph);
        case (ph)
            PhSeed:  return RNG_SEED;
            PhCtrl:  return RNG_CTRL;
            default: return RNG_VAL;
        endcase
    endfunction

endpackage

// File: rtl/apb4_rng_fetch_if.sv
// APB4 bus bundle between the RNG fetch master and the apb4_rng slave.
interface apb4_rng_fetch_if;

    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb4_rng_fetch_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module apb4_rng_fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop;

    assign w_pop   = pop_i & ~empty_o;
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count_o = r_wr_ptr - r_rd_ptr;
    // Masked while empty so the head reads as zero out of reset.
    assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/apb4_rng_fetch.sv
// APB4 master: seeds and enables apb4_rng, then streams RNG_VAL reads through a FIFO.
module apb4_rng_fetch
    import apb4_rng_fetch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [31:0]      seed_i,
    apb4_rng_fetch_if.master apb,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fsm_state_e r_state, w_state_d;
    phase_e     r_phase, w_phase_d;
    logic       r_run, w_run_d;
    logic       r_err, w_err_d;
    logic [31:0] r_seed, w_seed_d;

    logic        r_psel, r_penable, r_pwrite;
    logic [31:0] r_paddr, r_pwdata;
    logic [3:0]  r_pstrb;
    logic        w_psel_d, w_penable_d, w_pwrite_d;
    logic [31:0] w_paddr_d, w_pwdata_d;
    logic [3:0]  w_pstrb_d;

    logic          w_push, w_pop, w_full, w_empty;
    logic [CW-1:0] w_count, w_count_next;

    assign w_push = (r_state == StAccess) && apb.pready && !apb.pslverr && (r_phase == PhFetch);
    assign w_pop  = ready_i & ~w_empty;
    // Occupancy after this edge; a new read is only launched if it still has a free slot.
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    apb4_rng_fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (apb.prdata),
        .pop_i   (w_pop),
        .data_o  (data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_comb begin
        w_state_d = r_state;
        w_phase_d = r_phase;
        w_run_d   = r_run & ~stop_i;
        w_err_d   = r_err;
        w_seed_d  = r_seed;
        unique case (r_state)
            StIdle: begin
                if (start_i && !stop_i) begin
                    w_err_d   = 1'b0;
                    w_seed_d  = seed_i;
                    w_phase_d = PhSeed;
                    w_run_d   = 1'b1;
                    w_state_d = StSetup;
                end else if (r_phase == PhFetch && w_run_d && !w_full) begin
                    w_state_d = StSetup;
                end
            end
            StSetup: w_state_d = StAccess;
            StAccess: begin
                if (apb.pready) begin
                    if (apb.pslverr) begin
                        w_err_d   = 1'b1;
                        w_run_d   = 1'b0;
                        w_state_d = StIdle;
                    end else begin
                        w_phase_d = (r_phase == PhSeed) ? PhCtrl : PhFetch;
                        w_state_d = (w_phase_d != PhFetch || (w_run_d && w_count_next < DEPTH_C))
                                  ? StSetup : StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Bus outputs are decoded from the next state so they arrive registered with the state.
    always_comb begin
        w_psel_d    = (w_state_d != StIdle);
        w_penable_d = (w_state_d == StAccess);
        w_pwrite_d  = w_psel_d && (w_phase_d != PhFetch);
        w_paddr_d   = w_psel_d ? BASE_ADDR + phase_offset(w_phase_d) : '0;
        w_pwdata_d  = '0;
        if (w_pwrite_d) w_pwdata_d = (w_phase_d == PhSeed) ? w_seed_d : RNG_CTRL_EN;
        w_pstrb_d   = w_pwrite_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_phase   <= PhSeed;
            r_run     <= 1'b0;
            r_err     <= 1'b0;
            r_seed    <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_phase   <= w_phase_d;
            r_run     <= w_run_d;
            r_err     <= w_err_d;
            r_seed    <= w_seed_d;
            r_psel    <= w_psel_d;
            r_penable <= w_penable_d;
            r_pwrite  <= w_pwrite_d;
            r_paddr   <= w_paddr_d;
            r_pwdata  <= w_pwdata_d;
            r_pstrb   <= w_pstrb_d;
        end
    end

    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwrite  = r_pwrite;
    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;
    assign apb.pstrb   = r_pstrb;
    assign apb.pprot   = 3'b000;

    assign valid_o = ~w_empty;
    assign busy_o  = (r_state != StIdle);
    assign err_o   = r_err;

endmodule
